// File: rtl/sparse_dot_pkg.sv
// Shared types and helpers for the sparse dot-product engine.
//   state_t  : engine sequencing states
//   CNTW     : nonzero-count width for the default channel count
//   saturate : clamps a sign-extended accumulator value to an ow-bit signed range
//              and reports whether clamping happened
package sparse_dot_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPRESS = 2'd1,
        MAC      = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int N_DEFAULT = 20;
    localparam int CNTW      = $clog2(N_DEFAULT + 1);

    // Saturation works on a fixed wide carrier so the helper stays independent
    // of the per-instance accumulator width; callers sign-extend into it.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    flag;
        logic signed [SAT_W-1:0] value;
    } sat_t;

    function automatic sat_t saturate(input logic signed [SAT_W-1:0] value, input int ow);
        sat_t                    r;
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one     = 1;
        hi      = (one <<< (ow - 1)) - one;
        lo      = -(one <<< (ow - 1));
        r.flag  = 1'b0;
        r.value = value;
        if (value > hi) begin
            r.value = hi;
            r.flag  = 1'b1;
        end else if (value < lo) begin
            r.value = lo;
            r.flag  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sparse_compressor.sv
// Zero-compressing store for one operand vector, fed one channel per step.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of all state (start of a new vector)
//   step       : consume 'element' as channel 'i'
//   i          : channel index of the element being consumed
//   element    : operand value for channel i
//   bitmap     : bit k set when channel k was nonzero
//   elems      : nonzero values packed densely from slot 0
//   prefix     : prefix[k] = number of nonzeros in channels 0..k
//   nnz        : running nonzero count
module sparse_compressor
    import sparse_dot_pkg::*;
#(
    parameter int N   = 20,
    parameter int ELW = 9,
    parameter int CW  = $clog2(N + 1),
    parameter int IW  = $clog2(N)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     step,
    input  logic [IW-1:0]            i,
    input  logic [ELW-1:0]           element,
    output logic [N-1:0]             bitmap,
    output logic [N-1:0][ELW-1:0]    elems,
    output logic [N-1:0][CW-1:0]     prefix,
    output logic [CW-1:0]            nnz
);

    logic          nz;
    logic [CW-1:0] nnz_next;

    assign nz       = |element;
    assign nnz_next = nnz + CW'(nz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap <= '0;
            elems  <= '0;
            prefix <= '0;
            nnz    <= '0;
        end else if (clr) begin
            bitmap <= '0;
            elems  <= '0;
            prefix <= '0;
            nnz    <= '0;
        end else if (step) begin
            // Slot select by compare keeps the count at full CW width, so a
            // fully dense vector (count reaching N) never wraps the index.
            if (nz) begin
                for (int k = 0; k < N; k++) begin
                    if (nnz == CW'(k)) elems[k] <= element;
                end
            end
            bitmap[i] <= nz;
            prefix[i] <= nnz_next;
            nnz       <= nnz_next;
        end
    end

endmodule

// File: rtl/sparse_dot_engine.sv
// Sparse dot-product neuron: captures N activations and N weights, compresses
// each to nonzero stores, multiply-accumulates only where both are nonzero,
// then saturates (optionally ReLU) and hands the result downstream.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start / ready         : request handshake, ready only in IDLE
//   relu_en               : clamp negative results to zero (sampled at accept)
//   act_in / wgt_in       : packed operands, channel k at [k*W +: W]
//   out_valid / out_ready : result handshake
//   out_neuron, sat       : saturated result and saturation flag
//   nnz_act, nnz_wgt      : nonzero counts of the two operands
//
// state    | meaning
// IDLE     | waiting for start; ready=1
// COMPRESS | one channel per cycle into the nonzero stores
// MAC      | one channel per cycle, accumulate where both operands nonzero
// DONE     | register result, then hold it until out_ready
module sparse_dot_engine
    import sparse_dot_pkg::*;
#(
    parameter int N    = 20,
    parameter int AW   = 9,
    parameter int WW   = 2,
    parameter int OW   = 13,
    parameter int ACCW = AW + WW + $clog2(N)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    ready,
    input  logic                    relu_en,
    input  logic [N*AW-1:0]         act_in,
    input  logic [N*WW-1:0]         wgt_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OW-1:0]    out_neuron,
    output logic                    sat,
    output logic [$clog2(N+1)-1:0]  nnz_act,
    output logic [$clog2(N+1)-1:0]  nnz_wgt
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);
    localparam int PW = AW + WW;

    state_t state_q, state_d;

    logic [IW-1:0]          i_q;
    logic                   last;
    logic [N*AW-1:0]        act_q;
    logic [N*WW-1:0]        wgt_q;
    logic                   relu_q;
    logic signed [ACCW-1:0] acc;

    logic accept, mac_en, load_out, out_done;

    logic [N-1:0]          bm_a, bm_w, and_op;
    logic [N-1:0][AW-1:0]  els_a;
    logic [N-1:0][WW-1:0]  els_w;
    logic [N-1:0][CW-1:0]  pfx_a, pfx_w;
    logic [CW-1:0]         cnt_a, cnt_w;

    logic [AW-1:0]          a_sel;
    logic [WW-1:0]          w_sel;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;

    logic signed [SAT_W-1:0] acc_ext;
    sat_t                    sat_r;
    logic signed [OW-1:0]    res_val;
    logic                    res_sat;

    assign last   = (i_q == IW'(N - 1));
    assign ready  = (state_q == IDLE);
    assign and_op = bm_a & bm_w;

    sparse_compressor #(.N(N), .ELW(AW), .CW(CW), .IW(IW)) u_act_comp (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .step    (state_q == COMPRESS),
        .i       (i_q),
        .element (act_q[i_q*AW +: AW]),
        .bitmap  (bm_a),
        .elems   (els_a),
        .prefix  (pfx_a),
        .nnz     (cnt_a)
    );

    sparse_compressor #(.N(N), .ELW(WW), .CW(CW), .IW(IW)) u_wgt_comp (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .step    (state_q == COMPRESS),
        .i       (i_q),
        .element (wgt_q[i_q*WW +: WW]),
        .bitmap  (bm_w),
        .elems   (els_w),
        .prefix  (pfx_w),
        .nnz     (cnt_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        mac_en   = 1'b0;
        load_out = 1'b0;
        out_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = COMPRESS;
                end
            end
            COMPRESS: begin
                if (last) state_d = MAC;
            end
            MAC: begin
                mac_en = and_op[i_q];
                if (last) state_d = DONE;
            end
            DONE: begin
                // First DONE cycle registers the result; afterwards wait for out_ready.
                if (!out_valid) begin
                    load_out = 1'b1;
                end else if (out_ready) begin
                    out_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // prefix[i]-1 is the compressed slot of channel i; only used when the
    // channel is nonzero, so the prefix is at least 1 there.
    always_comb begin
        a_sel = '0;
        w_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (pfx_a[i_q] == CW'(k + 1)) a_sel = els_a[k];
            if (pfx_w[i_q] == CW'(k + 1)) w_sel = els_w[k];
        end
    end

    assign prod     = $signed(a_sel) * $signed(w_sel);
    assign prod_ext = {{(ACCW - PW){prod[PW-1]}}, prod};

    always_comb begin
        acc_ext = {{(SAT_W - ACCW){acc[ACCW-1]}}, acc};
        sat_r   = saturate(acc_ext, OW);
        res_val = sat_r.value[OW-1:0];
        res_sat = sat_r.flag;
        if (relu_q && acc[ACCW-1]) begin
            res_val = '0;
            res_sat = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q        <= '0;
            act_q      <= '0;
            wgt_q      <= '0;
            relu_q     <= 1'b0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_neuron <= '0;
            sat        <= 1'b0;
            nnz_act    <= '0;
            nnz_wgt    <= '0;
        end else begin
            if (accept) begin
                act_q  <= act_in;
                wgt_q  <= wgt_in;
                relu_q <= relu_en;
                acc    <= '0;
                i_q    <= '0;
            end else if (state_q == COMPRESS || state_q == MAC) begin
                i_q <= last ? '0 : i_q + IW'(1);
            end

            if (mac_en) acc <= acc + prod_ext;

            if (load_out) begin
                out_valid  <= 1'b1;
                out_neuron <= res_val;
                sat        <= res_sat;
                nnz_act    <= cnt_a;
                nnz_wgt    <= cnt_w;
            end else if (out_done) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sparse_dot_engine.sv
module tb_sparse_dot_engine;

    localparam int N  = 20;
    localparam int AW = 9;
    localparam int WW = 2;
    localparam int OW = 13;
    localparam int CW = $clog2(N + 1);
    localparam int LAT = 2 * N + 1;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic                   ready;
    logic                   relu_en;
    logic [N*AW-1:0]        act_in;
    logic [N*WW-1:0]        wgt_in;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [OW-1:0]   out_neuron;
    logic                   sat;
    logic [CW-1:0]          nnz_act;
    logic [CW-1:0]          nnz_wgt;

    sparse_dot_engine #(.N(N), .AW(AW), .WW(WW), .OW(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ready      (ready),
        .relu_en    (relu_en),
        .act_in     (act_in),
        .wgt_in     (wgt_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_neuron (out_neuron),
        .sat        (sat),
        .nnz_act    (nnz_act),
        .nnz_wgt    (nnz_wgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [OW-1:0] neuron;
        logic                 sat;
        logic [CW-1:0]        na;
        logic [CW-1:0]        nw;
    } res_t;

    res_t sb[$];
    int   act_v[N];
    int   wgt_v[N];
    int   errors = 0;
    int   checks = 0;

    function automatic res_t observed();
        res_t o;
        o.neuron = out_neuron;
        o.sat    = sat;
        o.na     = nnz_act;
        o.nw     = nnz_wgt;
        return o;
    endfunction

    task automatic push_expected(input bit relu);
        int   sum;
        int   na;
        int   nw;
        int   hi;
        int   lo;
        res_t e;
        sum = 0; na = 0; nw = 0;
        hi  = (1 << (OW - 1)) - 1;
        lo  = -(1 << (OW - 1));
        for (int k = 0; k < N; k++) begin
            sum += act_v[k] * wgt_v[k];
            if (act_v[k] != 0) na++;
            if (wgt_v[k] != 0) nw++;
        end
        e.sat = 1'b0;
        if (relu && sum < 0) sum = 0;
        else if (sum > hi) begin sum = hi; e.sat = 1'b1; end
        else if (sum < lo) begin sum = lo; e.sat = 1'b1; end
        e.neuron = OW'(sum);
        e.na     = CW'(na);
        e.nw     = CW'(nw);
        sb.push_back(e);
    endtask

    task automatic load_inputs();
        for (int k = 0; k < N; k++) begin
            act_in[k*AW +: AW] = AW'(act_v[k]);
            wgt_in[k*WW +: WW] = WW'(wgt_v[k]);
        end
    endtask

    task automatic scramble_inputs();
        for (int k = 0; k < N; k++) begin
            act_in[k*AW +: AW] = AW'($urandom);
            wgt_in[k*WW +: WW] = WW'($urandom);
        end
    endtask

    // Launches one operation from IDLE and waits (bounded) for out_valid.
    task automatic drive_op(input bit relu, input bit early_ready, output int lat, output bit ok);
        load_inputs();
        @(negedge clk);
        start     = 1'b1;
        relu_en   = relu;
        out_ready = early_ready;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        relu_en = ~relu;
        scramble_inputs();
        lat = 0;
        ok  = 1'b0;
        while (lat < 200 && !ok) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) ok = 1'b1;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
        act_in = '0; wgt_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || ready !== 1'b1 || observed() !== res_t'(0)) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b out=%0d sat=%b na=%0d nw=%0d required valid=0 ready=1 rest=0",
                     out_valid, ready, out_neuron, sat, nnz_act, nnz_wgt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b required 1/0", ready, out_valid);
        end
    endtask

    task automatic run_and_check(input string name, input bit relu, input bit early_ready);
        int   lat;
        bit   ok;
        res_t e;
        res_t o;
        push_expected(relu);
        drive_op(relu, early_ready, lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || lat != LAT) begin
            errors++;
            $display("FAIL %s_latency: got=%0d valid_seen=%b required=%0d", name, lat, ok, LAT);
        end
        o = observed();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s_result: got out=%0d sat=%b na=%0d nw=%0d required out=%0d sat=%b na=%0d nw=%0d",
                     name, o.neuron, o.sat, o.na, o.nw, e.neuron, e.sat, e.na, e.nw);
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: valid=%b ready=%b required 0/1", name, out_valid, ready);
        end
    endtask

    task automatic test_dense();
        for (int k = 0; k < N; k++) begin act_v[k] = 1; wgt_v[k] = 1; end
        run_and_check("dense", 1'b0, 1'b0);
    endtask

    task automatic test_sparse();
        for (int k = 0; k < N; k++) begin
            act_v[k] = k;
            wgt_v[k] = (k % 2 == 0) ? 1 : 0;
        end
        run_and_check("sparse", 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        int a_tab[3] = '{255, -256, -256};
        int w_tab[3] = '{1, 1, -2};
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < N; k++) begin act_v[k] = a_tab[c]; wgt_v[k] = w_tab[c]; end
            run_and_check($sformatf("sat%0d", c), 1'b0, 1'b0);
        end
    endtask

    task automatic test_relu();
        for (int k = 0; k < N; k++) begin act_v[k] = 0; wgt_v[k] = 0; end
        act_v[0] = -5;
        wgt_v[0] = 1;
        run_and_check("relu_on", 1'b1, 1'b1);
        run_and_check("relu_off", 1'b0, 1'b0);
    endtask

    task automatic test_zero_operand();
        for (int k = 0; k < N; k++) begin act_v[k] = 0; wgt_v[k] = int'($urandom_range(0, 3)) - 2; end
        run_and_check("zero_act", 1'b0, 1'b0);
    endtask

    task automatic test_handshake();
        int   lat;
        bit   ok;
        res_t e;
        res_t o;
        int   bad;
        for (int k = 0; k < N; k++) begin
            act_v[k] = int'($urandom_range(0, 40)) - 20;
            wgt_v[k] = int'($urandom_range(0, 3)) - 2;
        end
        push_expected(1'b0);
        drive_op(1'b0, 1'b0, lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || lat != LAT) begin
            errors++;
            $display("FAIL hold_latency: got=%0d valid_seen=%b required=%0d", lat, ok, LAT);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = (c == 5);
            @(posedge clk);
            #1;
            o = observed();
            checks++;
            if (o !== e || ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: out=%0d sat=%b valid=%b ready=%b required out=%0d sat=%b valid=1 ready=0",
                         c, o.neuron, o.sat, out_valid, ready, e.neuron, e.sat);
            end
        end
        start = 1'b0;
        release_out();
        checks++;
        if (out_valid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: valid=%b ready=%b required 0/1", out_valid, ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b1 || out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ignored_start: bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_reset_mid_mac();
        int bad;
        for (int k = 0; k < N; k++) begin act_v[k] = 3; wgt_v[k] = 1; end
        load_inputs();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ready !== 1'b1 || out_neuron !== '0) begin
            errors++;
            $display("FAIL mid_mac_reset: valid=%b ready=%b out=%0d required 0/1/0", out_valid, ready, out_neuron);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_mac_no_result: bad_cycles=%0d required 0", bad);
        end
        for (int k = 0; k < N; k++) begin act_v[k] = 1; wgt_v[k] = 0; end
        run_and_check("after_reset", 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_dense();
        test_sparse();
        test_saturation();
        test_relu();
        test_zero_operand();
        test_handshake();
        test_reset_mid_mac();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sparse_dot_engine.md
Name: sparse_dot_engine

Overview:
- Parametrised sparse dot-product neuron, the successor to the fixed 20-input DIM neuron.
- Captures N signed activations and N signed weights and builds per-operand nonzero bitmaps and zero-compressed element stores with prefix-count indices.
- Multiply-accumulates only positions where both operands are nonzero.
- Adds start/ready and valid/ready handshakes, output saturation, an optional ReLU mode and nonzero-count reporting; sits between the layer buffer and the next-layer activation buffer.

Parameters:
- N, 20, number of input channels (2..64)
- AW, 9, activation width, signed
- WW, 2, weight width, signed
- OW, 13, output width, signed, saturated
- ACCW, AW+WW+$clog2(N), internal accumulator width; never truncated before saturation

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new dot product; accepted when start && ready
- ready  out  1  high only in IDLE
- relu_en  in  1  sampled at accept; 1 = clamp negative result to 0
- act_in  in  N*AW  packed activations, channel k at [k*AW +: AW]; sampled at accept only
- wgt_in  in  N*WW  packed weights, same packing; sampled at accept only
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_neuron  out  OW  signed saturated (optionally ReLU'd) dot product
- sat  out  1  saturation occurred on this result
- nnz_act  out  $clog2(N+1)  count of nonzero activations
- nnz_wgt  out  $clog2(N+1)  count of nonzero weights

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; ready=1.
  - out_valid, out_neuron, sat, nnz_act, nnz_wgt, accumulator, bitmaps and channel counter are all 0.
- FSM states: IDLE -> COMPRESS -> MAC -> DONE -> IDLE.
- IDLE:
  - On start && ready, latch act_in, wgt_in and relu_en, clear bitmaps, counts and accumulator, set i=0, go to COMPRESS.
  - start while not ready is ignored; it is neither queued nor an error.
- COMPRESS (one channel per cycle, i = 0..N-1):
  - Act_Index[i] = (act[i] != 0). If nonzero, store act[i] at Act_element[cnt_a] and increment cnt_a.
  - Inc_Act[i] = cnt_a after the update. Weights are handled identically.
  - After i = N-1: i = 0, and_op = Act_Index & Weight_Index, go to MAC.
- MAC (one channel per cycle, i = 0..N-1):
  - If and_op[i], acc += Weight_element[Inc_Weight[i]-1] * Act_element[Inc_Act[i]-1], as a full-precision signed product sign-extended to ACCW.
  - After i = N-1, go to DONE.
- DONE:
  - Register the result: if relu_en and acc < 0, the result is 0; else it is acc saturated to [-2^(OW-1), 2^(OW-1)-1].
  - sat=1 iff clamping by saturation occurred; a ReLU clamp does not set sat.
  - Drive nnz_act and nnz_wgt; out_valid=1.
  - Hold all outputs stable while out_valid && !out_ready.
  - On out_ready, drop out_valid next cycle and return to IDLE.
  - out_neuron, sat and nnz_* keep their value until the next result.
- Latency: accept at cycle 0 -> out_valid at cycle 2N+1. The latency is fixed and independent of sparsity.
- Boundaries:
  - All-zero operand: no MAC updates; result 0, sat=0.
  - Fully dense operands: cnt reaches N, and index arithmetic must cover N without wrap.
  - Most-negative weight × most-negative activation is positive and must not overflow ACCW.
  - rst_n asserted mid-COMPRESS or mid-MAC aborts immediately. No partial result is emitted and out_valid stays 0.
  - out_ready high before out_valid has no effect.

Decomposition:
- Package sparse_dot_pkg holds:
  - state enum {IDLE, COMPRESS, MAC, DONE}
  - saturate function (ACCW -> OW, returns value and flag)
  - localparam CNTW = $clog2(N+1)
- Natural sub-module: sparse_compressor, instantiated twice (activation, weight), parameter ELW.
  - Inputs: clk, rst_n, clr, step, i, element.
  - Outputs: bitmap, compressed element array, prefix-count array, nnz count.
- The top level holds the FSM, MAC, saturation/ReLU and handshakes.

Test Plan:
- N=20, all act=1, all wgt=1, relu_en=0 -> out_neuron=20, sat=0, nnz_act=20, nnz_wgt=20, out_valid at cycle 41 after accept.
- Sparse pattern: act[k]=k for k=0..19 (k=0 is zero); wgt=1 on even k, 0 on odd k -> out_neuron=90 (2+4+...+18), nnz_act=19, nnz_wgt=10.
- Saturation: all act=255, wgt=1 -> true sum 5100 -> out_neuron=4095, sat=1. All act=-256, wgt=1 -> -5120 -> out_neuron=-4096, sat=1. All act=-256, wgt=-2 -> 10240 -> out_neuron=4095, sat=1.
- ReLU: act=-5 on channel 0, wgt=1, others 0, relu_en=1 -> out_neuron=0, sat=0. Same stimulus with relu_en=0 -> out_neuron=-5.
- Handshake: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and ready=0. A start pulse during that window is ignored. out_ready=1 -> ready=1 on the next cycle.
- Reset mid-MAC: assert rst_n=0 at cycle 25 after accept -> out_valid=0 and ready=1 after release. A new start with all-zero weights -> out_neuron=0, nnz_wgt=0.
